// File: rtl/sm3_cf_arbiter.sv
// Round-robin arbiter sharing one sm3_CF compression core among NREQ requesters.
// Optional watchdog enabled by defining CF_TIMEOUT_EN (limit set by TIMEOUT).
module sm3_cf_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [256*NREQ-1:0]    req_iv,
  input  logic [512*NREQ-1:0]    req_blk,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [255:0]           result,
  output logic                   err,
  output logic                   busy,
  output logic                   cf_start,
  output logic [255:0]           cf_iv,
  output logic [511:0]           cf_msg,
  input  logic [255:0]           cf_hash,
  input  logic                   cf_end
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [NREQ-1:0]   done_reg, done_next;
  logic [255:0]      result_reg, result_next;
  logic              cf_start_reg, cf_start_next;
  logic [255:0]      cf_iv_reg, cf_iv_next;
  logic [511:0]      cf_msg_reg, cf_msg_next;
  logic [IW-1:0]     last_reg, last_next;
  logic [IW-1:0]     winner_reg, winner_next;
  logic [IW-1:0]     pick;
  logic              found;

`ifdef CF_TIMEOUT_EN
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WW-1:0]     wd_reg, wd_next;
  logic              err_reg, err_next;
`endif

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last_reg;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last_reg) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(last_reg) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    done_next     = '0;
    result_next   = result_reg;
    cf_start_next = cf_start_reg;
    cf_iv_next    = cf_iv_reg;
    cf_msg_next   = cf_msg_reg;
    last_next     = last_reg;
    winner_next   = winner_reg;
`ifdef CF_TIMEOUT_EN
    wd_next       = wd_reg;
    err_next      = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next    = NREQ'(1) << pick;
          winner_next   = pick;
          cf_iv_next    = req_iv[256*pick +: 256];
          cf_msg_next   = req_blk[512*pick +: 512];
          cf_start_next = 1'b1;
          state_next    = RUN;
`ifdef CF_TIMEOUT_EN
          wd_next       = '0;
`endif
        end
      end
      RUN: begin
        if (cf_end) begin
          cf_start_next = 1'b0;
          result_next   = cf_hash;
          done_next     = NREQ'(1) << winner_reg;
          grant_next    = '0;
          last_next     = winner_reg;
          state_next    = GAP;
        end
`ifdef CF_TIMEOUT_EN
        else if (wd_reg == WW'(TIMEOUT - 1)) begin
          cf_start_next = 1'b0;
          result_next   = '0;
          done_next     = NREQ'(1) << winner_reg;
          err_next      = 1'b1;
          grant_next    = '0;
          last_next     = winner_reg;
          state_next    = GAP;
        end else begin
          wd_next       = wd_reg + 1'b1;
        end
`endif
      end
      GAP: begin
        grant_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      done_reg     <= '0;
      result_reg   <= '0;
      cf_start_reg <= 1'b0;
      cf_iv_reg    <= '0;
      cf_msg_reg   <= '0;
      last_reg     <= IW'(NREQ - 1);
      winner_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      cf_start_reg <= cf_start_next;
      cf_iv_reg    <= cf_iv_next;
      cf_msg_reg   <= cf_msg_next;
      last_reg     <= last_next;
      winner_reg   <= winner_next;
    end
  end

`ifdef CF_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      wd_reg  <= wd_next;
      err_reg <= err_next;
    end
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign grant    = grant_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign busy     = (state_reg != IDLE);
  assign cf_start = cf_start_reg;
  assign cf_iv    = cf_iv_reg;
  assign cf_msg   = cf_msg_reg;

endmodule
